// File: rtl/uart_tx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_pkg
// Description : Shared UART definitions: parity modes, FSM state encodings
//               and the baud divider helper. Intended for reuse by a uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_frame_pkg;

    // Parity modes
    localparam int c_parity_none = 0;
    localparam int c_parity_odd  = 1;
    localparam int c_parity_even = 2;

    // Frame state encodings
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle   = 3'd0;
    localparam state_t c_st_start  = 3'd1;
    localparam state_t c_st_data   = 3'd2;
    localparam state_t c_st_parity = 3'd3;
    localparam state_t c_st_stop   = 3'd4;

    // Rounded clocks-per-bit
    function automatic int calc_divider(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period timer. Emits a one-cycle tick every DIVIDER
//               cycles; restart holds the count at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIVIDER = 434
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int c_cnt_w = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIVIDER - 1);

    logic [c_cnt_w-1:0] r_count;

    // Free-running modulo-DIVIDER counter, cleared while restart is high
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (restart || (r_count == c_last)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmitter: start bit, DATA_BITS data bits LSB first,
//               optional parity, 1 or 2 stop bits. ready/start handshake
//               allows back-to-back frames with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 start,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 tx
);

    localparam int       c_divider    = calc_divider(CLOCK_FREQUENCY, BAUD_RATE);
    localparam bit       c_has_parity = (PARITY != c_parity_none);
    localparam logic [3:0] c_last_data = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);

    generate
        if ((c_divider < 2) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
            (PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_params
            $error("uart_tx_frame: illegal parameter combination");
        end
    endgenerate

    state_t               r_state, w_state_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_parity, w_parity_next;
    logic [3:0]           r_bit_cnt, w_bit_cnt_next;
    logic                 r_tx, w_tx_next;
    logic                 r_done, w_done_next;
    logic                 w_ready;
    logic                 w_tick;
    logic                 w_restart;
    logic                 w_parity_calc;

    // Bit timer is parked at zero while idle so a new frame starts a full bit
    assign w_restart = (r_state == c_st_idle);

    uart_baud_tick #(
        .DIVIDER (c_divider)
    ) u_baud_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Even parity bit is the XOR of the data bits; odd is its complement
    assign w_parity_calc = (PARITY == c_parity_even) ? (^data) : ~(^data);

    // State, datapath and registered line output
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_st_idle;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
            r_done    <= w_done_next;
        end
    end

    // Next-state logic; ready is also high in the final cycle of the last
    // stop bit so a waiting start is taken on the frame-end edge itself
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_bit_cnt_next = r_bit_cnt;
        w_tx_next      = r_tx;
        w_done_next    = 1'b0;
        w_ready        = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_ready   = 1'b1;
                w_tx_next = 1'b1;
            end
            c_st_start: begin
                if (w_tick) begin
                    w_state_next   = c_st_data;
                    w_tx_next      = r_shift[0];
                    w_shift_next   = {1'b0, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_next = '0;
                end
            end
            c_st_data: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_last_data) begin
                        w_bit_cnt_next = '0;
                        if (c_has_parity) begin
                            w_state_next = c_st_parity;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = c_st_stop;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                        w_tx_next      = r_shift[0];
                        w_shift_next   = {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end
            end
            c_st_parity: begin
                if (w_tick) begin
                    w_state_next   = c_st_stop;
                    w_tx_next      = 1'b1;
                    w_bit_cnt_next = '0;
                end
            end
            c_st_stop: begin
                if (w_tick) begin
                    if (r_bit_cnt == c_last_stop) begin
                        w_ready      = 1'b1;
                        w_done_next  = 1'b1;
                        w_state_next = c_st_idle;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = c_st_idle;
                w_tx_next    = 1'b1;
            end
        endcase

        if (start && w_ready) begin
            w_state_next   = c_st_start;
            w_shift_next   = data;
            w_parity_next  = w_parity_calc;
            w_bit_cnt_next = '0;
            w_tx_next      = 1'b0;
        end
    end

    assign ready = w_ready;
    assign busy  = ~w_ready;
    assign done  = r_done;
    assign tx    = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Directed self-checking bench for uart_tx_frame with four
//               configurations (8N1, 8E1, 8O1, 7N2) at DIVIDER = 10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic       start_a, ready_a, busy_a, done_a, tx_a;
    logic [7:0] data_a;
    logic       start_e, ready_e, busy_e, done_e, tx_e;
    logic [7:0] data_e;
    logic       start_o, ready_o, busy_o, done_o, tx_o;
    logic [7:0] data_o;
    logic       start_s, ready_s, busy_s, done_s, tx_s;
    logic [6:0] data_s;

    int checks   = 0;
    int failures = 0;

    uart_tx_frame #(.CLOCK_FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
        .clock(clock), .reset_n(reset_n), .data(data_a), .start(start_a),
        .ready(ready_a), .busy(busy_a), .done(done_a), .tx(tx_a));
    uart_tx_frame #(.CLOCK_FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8e1 (
        .clock(clock), .reset_n(reset_n), .data(data_e), .start(start_e),
        .ready(ready_e), .busy(busy_e), .done(done_e), .tx(tx_e));
    uart_tx_frame #(.CLOCK_FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_8o1 (
        .clock(clock), .reset_n(reset_n), .data(data_o), .start(start_o),
        .ready(ready_o), .busy(busy_o), .done(done_o), .tx(tx_o));
    uart_tx_frame #(.CLOCK_FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_7n2 (
        .clock(clock), .reset_n(reset_n), .data(data_s), .start(start_s),
        .ready(ready_s), .busy(busy_s), .done(done_s), .tx(tx_s));

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (tx_a !== 1'b1)    begin failures++; $display("FAIL reset_tx actual=%b required=1", tx_a); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%b required=1", ready_a); end
        checks++; if (busy_a !== 1'b0)  begin failures++; $display("FAIL reset_busy actual=%b required=0", busy_a); end
        checks++; if (done_a !== 1'b0)  begin failures++; $display("FAIL reset_done actual=%b required=0", done_a); end
        checks++; if ({tx_e, tx_o, tx_s} !== 3'b111) begin failures++; $display("FAIL reset_tx_others actual=%b required=111", {tx_e, tx_o, tx_s}); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if ({tx_a, ready_a, busy_a, done_a} !== 4'b1100) begin failures++; $display("FAIL idle_after_reset actual=%b required=1100", {tx_a, ready_a, busy_a, done_a}); end
    endtask

    task automatic test_8n1;
        logic [9:0] fr;
        logic       exp_tx;
        fr = {1'b1, 8'h55, 1'b0};
        @(negedge clock);
        data_a  = 8'h55;
        start_a = 1'b1;
        for (int k = 0; k <= 101; k++) begin
            @(posedge clock);
            #1;
            exp_tx = (k < 100) ? fr[k/10] : 1'b1;
            checks++; if (tx_a !== exp_tx) begin failures++; $display("FAIL 8n1_tx edge=%0d actual=%b required=%b", k, tx_a, exp_tx); end
            checks++; if (done_a !== (k == 100)) begin failures++; $display("FAIL 8n1_done edge=%0d actual=%b required=%b", k, done_a, (k == 100)); end
            if (k != 99) begin
                checks++; if (ready_a !== (k >= 100)) begin failures++; $display("FAIL 8n1_ready edge=%0d actual=%b required=%b", k, ready_a, (k >= 100)); end
                checks++; if (busy_a !== (k < 100)) begin failures++; $display("FAIL 8n1_busy edge=%0d actual=%b required=%b", k, busy_a, (k < 100)); end
            end
            if (k == 0) begin
                @(negedge clock);
                start_a = 1'b0;
                data_a  = 8'hFF;
            end
        end
    endtask

    task automatic test_parity;
        logic [10:0] fr_e, fr_o;
        logic        exp_e, exp_o;
        fr_e = {1'b1, 1'b1, 8'h07, 1'b0};
        fr_o = {1'b1, 1'b0, 8'h07, 1'b0};
        @(negedge clock);
        data_e = 8'h07; start_e = 1'b1;
        data_o = 8'h07; start_o = 1'b1;
        for (int k = 0; k <= 111; k++) begin
            @(posedge clock);
            #1;
            exp_e = (k < 110) ? fr_e[k/10] : 1'b1;
            exp_o = (k < 110) ? fr_o[k/10] : 1'b1;
            checks++; if (tx_e !== exp_e) begin failures++; $display("FAIL even_tx edge=%0d actual=%b required=%b", k, tx_e, exp_e); end
            checks++; if (tx_o !== exp_o) begin failures++; $display("FAIL odd_tx edge=%0d actual=%b required=%b", k, tx_o, exp_o); end
            checks++; if (done_e !== (k == 110)) begin failures++; $display("FAIL even_done edge=%0d actual=%b required=%b", k, done_e, (k == 110)); end
            checks++; if (done_o !== (k == 110)) begin failures++; $display("FAIL odd_done edge=%0d actual=%b required=%b", k, done_o, (k == 110)); end
            if (k == 0) begin
                @(negedge clock);
                start_e = 1'b0; data_e = 8'h00;
                start_o = 1'b0; data_o = 8'h00;
            end
        end
    endtask

    task automatic test_7n2;
        logic [9:0] fr;
        logic       exp_tx;
        fr = {2'b11, 7'h41, 1'b0};
        @(negedge clock);
        data_s  = 7'h41;
        start_s = 1'b1;
        for (int k = 0; k <= 101; k++) begin
            @(posedge clock);
            #1;
            exp_tx = (k < 100) ? fr[k/10] : 1'b1;
            checks++; if (tx_s !== exp_tx) begin failures++; $display("FAIL 7n2_tx edge=%0d actual=%b required=%b", k, tx_s, exp_tx); end
            checks++; if (done_s !== (k == 100)) begin failures++; $display("FAIL 7n2_done edge=%0d actual=%b required=%b", k, done_s, (k == 100)); end
            if (k == 85 || k == 100) begin
                checks++; if (ready_s !== (k == 100)) begin failures++; $display("FAIL 7n2_ready edge=%0d actual=%b required=%b", k, ready_s, (k == 100)); end
            end
            if (k == 0) begin
                @(negedge clock);
                start_s = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] fr;
        logic        exp_tx;
        int          n_done;
        fr     = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
        n_done = 0;
        @(negedge clock);
        data_a  = 8'hA5;
        start_a = 1'b1;
        for (int k = 0; k <= 201; k++) begin
            @(posedge clock);
            #1;
            exp_tx = (k < 200) ? fr[k/10] : 1'b1;
            if (done_a === 1'b1) n_done++;
            checks++; if (tx_a !== exp_tx) begin failures++; $display("FAIL b2b_tx edge=%0d actual=%b required=%b", k, tx_a, exp_tx); end
            checks++; if (done_a !== (k == 100 || k == 200)) begin failures++; $display("FAIL b2b_done edge=%0d actual=%b required=%b", k, done_a, (k == 100 || k == 200)); end
            if (k == 100 || k == 200) begin
                checks++; if (busy_a !== (k == 100)) begin failures++; $display("FAIL b2b_busy edge=%0d actual=%b required=%b", k, busy_a, (k == 100)); end
            end
            if (k == 0) begin
                @(negedge clock); data_a = 8'h3C;
            end else if (k == 100) begin
                @(negedge clock); start_a = 1'b0;
            end else if (k == 150) begin
                @(negedge clock); data_a = 8'hFF;
            end
        end
        checks++; if (n_done != 2) begin failures++; $display("FAIL b2b_done_count actual=%0d required=2", n_done); end
    endtask

    task automatic test_reset_midframe;
        logic [9:0] fr;
        logic       exp_tx;
        @(negedge clock);
        data_a  = 8'h00;
        start_a = 1'b1;
        for (int k = 0; k <= 45; k++) begin
            @(posedge clock);
            #1;
            checks++; if (tx_a !== (k >= 10 ? 1'b0 : 1'b0)) begin failures++; $display("FAIL mid_tx edge=%0d actual=%b required=0", k, tx_a); end
            if (k == 0) begin
                @(negedge clock);
                start_a = 1'b0;
            end
        end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (tx_a !== 1'b1)    begin failures++; $display("FAIL async_rst_tx actual=%b required=1", tx_a); end
        checks++; if (busy_a !== 1'b0)  begin failures++; $display("FAIL async_rst_busy actual=%b required=0", busy_a); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL async_rst_ready actual=%b required=1", ready_a); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        fr = {1'b1, 8'hC3, 1'b0};
        @(negedge clock);
        data_a  = 8'hC3;
        start_a = 1'b1;
        for (int k = 0; k <= 101; k++) begin
            @(posedge clock);
            #1;
            exp_tx = (k < 100) ? fr[k/10] : 1'b1;
            checks++; if (tx_a !== exp_tx) begin failures++; $display("FAIL post_rst_tx edge=%0d actual=%b required=%b", k, tx_a, exp_tx); end
            checks++; if (done_a !== (k == 100)) begin failures++; $display("FAIL post_rst_done edge=%0d actual=%b required=%b", k, done_a, (k == 100)); end
            if (k == 0) begin
                @(negedge clock);
                start_a = 1'b0;
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [9:0] fr;
        logic       exp_tx;
        int         n_done;
        fr     = {1'b1, 8'h96, 1'b0};
        n_done = 0;
        @(negedge clock);
        data_a  = 8'h96;
        start_a = 1'b1;
        for (int k = 0; k <= 130; k++) begin
            @(posedge clock);
            #1;
            exp_tx = (k < 100) ? fr[k/10] : 1'b1;
            if (done_a === 1'b1) n_done++;
            checks++; if (tx_a !== exp_tx) begin failures++; $display("FAIL ignore_tx edge=%0d actual=%b required=%b", k, tx_a, exp_tx); end
            if (k == 0) begin
                @(negedge clock); start_a = 1'b0;
            end else if (k == 29) begin
                @(negedge clock); start_a = 1'b1; data_a = 8'hFF;
            end else if (k == 30) begin
                @(negedge clock); start_a = 1'b0;
            end
        end
        checks++; if (n_done != 1) begin failures++; $display("FAIL ignore_done_count actual=%0d required=1", n_done); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL ignore_ready_end actual=%b required=1", ready_a); end
    endtask

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0; data_a = '0;
        start_e = 1'b0; data_e = '0;
        start_o = 1'b0; data_o = '0;
        start_s = 1'b0; data_s = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_back_to_back();
        test_reset_midframe();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
